// File: rtl/in_out_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : in_out_sram_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing the single-port in/out SRAM
//            between NUM_REQ requesters, with a bounded burst lock and
//            one-cycle read response routing back to the issuing requester.
// Revision : 1.0 - initial release
// ============================================================================
module in_out_sram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 3,
    parameter int MAX_LOCK   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0]             req_we_i,
    input  logic [NUM_REQ-1:0]             req_lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [ADDR_WIDTH-1:0]          sram_addr_o,
    output logic [DATA_WIDTH-1:0]          sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

    localparam int         c_ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] c_ST_OPEN   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;
    localparam logic [8:0] c_MAX_LOCK  = 9'(MAX_LOCK);
    // A bound of one means a lock would expire on the very accept that takes it
    localparam bit         c_CAN_LOCK  = (MAX_LOCK > 1);

    // Wrap an integer requester position back into the requester range
    function automatic logic [c_ID_W-1:0] f_wrap(input int v);
        return c_ID_W'(v % NUM_REQ);
    endfunction

    // Lock state
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_ID_W-1:0] r_lock_owner;
    logic [c_ID_W-1:0] w_owner_nxt;
    logic [7:0]        r_lock_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_hold;

    // Arbitration
    logic [c_ID_W-1:0]  r_last_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_ID_W-1:0]  w_grant_id;
    logic               w_found;
    logic               w_accept;

    // SRAM command stage and response stage
    logic                  r_sram_req;
    logic                  r_sram_we;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_sram_wdata;
    logic [c_ID_W-1:0]     r_sram_id;
    logic [NUM_REQ-1:0]    r_rsp_valid;

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_OPEN;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_owner_nxt;
            r_lock_cnt   <= w_cnt_nxt;
        end
    end

    // Lock FSM next state: an idle owner releases the lock and the cycle is
    // arbitrated as if OPEN, so a new lock can be taken in that same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_lock_owner;
        w_cnt_nxt   = r_lock_cnt;
        if (w_hold) begin
            if (!req_lock_i[r_lock_owner] ||
                ({1'b0, r_lock_cnt} + 9'd1 >= c_MAX_LOCK)) begin
                w_state_nxt = c_ST_OPEN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_lock_cnt + 8'd1;
            end
        end else begin
            w_state_nxt = c_ST_OPEN;
            w_cnt_nxt   = '0;
            if (c_CAN_LOCK && w_accept && req_lock_i[w_grant_id]) begin
                w_state_nxt = c_ST_LOCKED;
                w_owner_nxt = w_grant_id;
                w_cnt_nxt   = 8'd1;
            end
        end
    end

    // Lock FSM output: the owner keeps exclusive access while it stays valid
    always_comb begin
        w_hold = 1'b0;
        if (r_state == c_ST_LOCKED) begin
            w_hold = req_valid_i[r_lock_owner];
        end
    end

    // Round-robin pick starting after the last grant, overridden by a live lock
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        if (w_hold) begin
            w_grant[r_lock_owner] = 1'b1;
            w_grant_id            = r_lock_owner;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!w_found && req_valid_i[f_wrap(int'(r_last_grant) + k)]) begin
                    w_found                                      = 1'b1;
                    w_grant_id                                   = f_wrap(int'(r_last_grant) + k);
                    w_grant[f_wrap(int'(r_last_grant) + k)]      = 1'b1;
                end
            end
        end
    end

    assign w_accept    = |w_grant;
    assign req_ready_o = rst_n ? w_grant : '0;

    // Remember the last winner so the next round starts just after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end

    // Register the accepted command into the SRAM stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_id    <= '0;
        end else begin
            r_sram_req <= w_accept;
            r_sram_we  <= w_accept & req_we_i[w_grant_id];
            if (w_accept) begin
                r_sram_addr  <= req_addr_i[w_grant_id*ADDR_WIDTH +: ADDR_WIDTH];
                r_sram_wdata <= req_wdata_i[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
                r_sram_id    <= w_grant_id;
            end
        end
    end

    // Raise the response strobe for the issuer when the SRAM read data lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_sram_req && !r_sram_we) begin
                r_rsp_valid[r_sram_id] <= 1'b1;
            end
        end
    end

    assign sram_req_o   = r_sram_req;
    assign sram_we_o    = r_sram_we;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;
    assign rsp_valid_o  = r_rsp_valid;
    // SRAM output is already registered; pass it through, forced to zero when idle
    assign rsp_rdata_o  = (|r_rsp_valid) ? sram_rdata_i : '0;

endmodule
`default_nettype wire

// File: doc/in_out_sram_arbiter.md
# in_out_sram_arbiter

Round-robin arbiter and sequencer that shares the single-port 8KB in/out SRAM (1024 x 64-bit, 1-cycle registered read) between NUM_REQ requesters, e.g. the host-side loader, the Octree traversal engine and the result writer. It accepts one request per cycle over a valid/ready handshake and registers the command into the SRAM. It routes the read data back to the issuing requester with a one-cycle response pulse. An optional bounded lock lets one requester run uninterrupted burst sequences.

## Interface
- ADDR_WIDTH, 10, SRAM word address width
- DATA_WIDTH, 64, SRAM data width
- NUM_REQ, 3, number of requesters (2..8)
- MAX_LOCK, 16, maximum consecutive locked grants before forced release (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  one-hot grant/accept, combinational
- req_we_i  in  NUM_REQ  per-requester write enable
- req_lock_i  in  NUM_REQ  request to keep the grant on the next cycle
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  addresses, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  write data, same slicing
- rsp_valid_o  out  NUM_REQ  one-hot read-data-valid pulse
- rsp_rdata_o  out  DATA_WIDTH  read data, qualified by rsp_valid_o
- sram_req_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  ADDR_WIDTH  SRAM address
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_rdata_i  in  DATA_WIDTH  SRAM read data

## Operation
- Arbitration is combinational each cycle over the requesters with req_valid_i set.
  - Round-robin starts from (last_grant+1) mod NUM_REQ.
  - At most one req_ready_o bit is high, and only for a valid requester.
  - Handshake: a request is accepted when req_valid_i[i] and req_ready_o[i] are both high.
- On accept:
  - last_grant becomes i.
  - The command (we, addr, wdata, id) is registered into the SRAM stage.
- Requesters hold valid/we/addr/wdata stable until accepted. The arbiter never drops an asserted request.
- Lock state machine, states OPEN and LOCKED:
  - OPEN -> LOCKED: on accept with req_lock_i[i]=1. lock_owner=i, lock_cnt=1.
  - LOCKED: only lock_owner can win; others see ready=0. Each locked accept increments lock_cnt.
  - LOCKED -> OPEN when any of these holds:
    - the owner's valid is low in a cycle;
    - the owner is accepted with req_lock_i low;
    - lock_cnt reaches MAX_LOCK on an accept.
  - Forced release at MAX_LOCK: the next arbitration starts at owner+1, so the owner does not win it if any other requester is valid.
- Reads:
  - rsp_valid_o[id] pulses for one cycle with rsp_rdata_o = sram_rdata_i.
  - Writes produce no response.
- Responses cannot be backpressured. Requesters must sink them.
- Ordering is strict issue order. A read after a write to the same address returns the new data, because the pipeline is in-order and single-port.
- No address or id checking. The full 1024-word space is reachable by every requester.

## Timing
- Reset values:
  - req_ready_o: 0 during reset, then combinational.
  - rsp_valid_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, rsp_rdata_o: 0.
  - Internal: last_grant = NUM_REQ-1, so requester 0 wins first; state OPEN; lock_cnt 0.
- Cycle N: accept. Cycle N+1: sram_req_o=1 with the registered command. Cycle N+2: rsp_valid_o for reads.
- sram_req_o is 0 in any cycle N+1 that has no accept at N. sram_we_o is 0 whenever sram_req_o is 0.
- Throughput is one accept per cycle with no bubbles. Back-to-back reads yield back-to-back responses.
- rsp_rdata_o is a registered copy of sram_rdata_i, or a direct pass-through; it only has to be valid while rsp_valid_o is high.
- Reset asserted mid-operation: in-flight commands and pending responses are discarded, and no response pulse appears after reset release.

## Test plan
- Single read: after reset, req0 reads addr 0x005, and the SRAM is preloaded with 0xDEADBEEF_00000005. Required: ready0 at N, sram_req_o/addr 0x005 at N+1, rsp_valid_o=3'b001 with that data at N+2.
- Round-robin: all three requesters hold valid for 6 cycles with no lock. Grants must be 0,1,2,0,1,2 and each response id must match.
- Write then read: req1 writes 0x3FF=0x0123456789ABCDEF, and req2 reads 0x3FF on the next cycle. Required: req2 receives 0x0123456789ABCDEF at its N+2.
- Lock bound: MAX_LOCK=4, req0 holds lock and valid continuously, req1 valid. Grants must be 0,0,0,0,1, and then req0 may lock again.
- Lock release on idle: req2 is locked, drops valid for one cycle while req0 is valid. req0 must be granted in that cycle.
- Reset mid-read: a read is accepted at N and rst_n is asserted at N+1. All outputs must be 0 and no rsp_valid_o pulse may occur after release.
